rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
- Shares the single write port of the 32x32 register file among NUM_REQ requesters, e.g. the ALU writeback, load unit, link-register write and debug port.
- Uses round-robin arbitration with a req/gnt handshake per requester.
- Holds the register-file write strobe until the file accepts it (rf_ready).
- Rejects writes to the hardwired-zero register and to out-of-range addresses, so the file never sees them.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 32, data width.
- ABITS, 5, register address width.
- NUM_REGS, 32, number of implemented registers.
- ZERO_REG, 31, index of the read-only zero register.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester write request; held high until gnt or err.
- req_addr  in  NUM_REQ*ABITS  packed target addresses; requester i uses bits [i*ABITS +: ABITS].
- req_data  in  NUM_REQ*WIDTH  packed write data; requester i uses bits [i*WIDTH +: WIDTH].
- gnt  out  NUM_REQ  one-cycle one-hot pulse: the write has been accepted by the file.
- err  out  NUM_REQ  one-cycle one-hot pulse: the write was rejected (protected or out-of-range address).
- rf_wr  out  1  write strobe to the register file.
- rf_select  out  ABITS  write address to the register file.
- rf_data  out  WIDTH  write data to the register file.
- rf_ready  in  1  register file accepts the write this cycle when rf_wr=1.
- busy  out  1  high when state=ISSUE.

Behaviour:
- Reset values (asynchronous, while rst=1): state=IDLE, rr_ptr=0, rf_wr=0, rf_select=0, rf_data=0, gnt=0, err=0, busy=0.
- FSM states: IDLE and ISSUE.
- Round-robin choice: the winner is the first i with req[i]=1, scanning upward from rr_ptr and wrapping modulo NUM_REQ.
- IDLE, req=0: stay in IDLE; all outputs stay low.
- IDLE, winner w with a bad address (req_addr[w]==ZERO_REG, or req_addr[w] >= NUM_REGS):
  - err[w]=1 in the same cycle (combinational from state and inputs);
  - rr_ptr <= (w+1) mod NUM_REQ;
  - stay in IDLE; rf_wr remains 0.
- IDLE, winner w with a legal address:
  - register rf_select <= req_addr[w], rf_data <= req_data[w], win <= w;
  - state <= ISSUE.
- ISSUE:
  - rf_wr=1 and busy=1; rf_select and rf_data are held stable.
  - When rf_ready=1: gnt[win]=1 combinationally in that cycle, rr_ptr <= (win+1) mod NUM_REQ, state <= IDLE.
  - When rf_ready=0: stay in ISSUE indefinitely. There is no timeout.
- Latency and throughput:
  - Request sampled in cycle n; rf_wr=1 in cycle n+1.
  - gnt arrives in the first cycle at or after n+1 in which rf_ready=1.
  - Peak throughput is one write per 2 cycles; there is a mandatory IDLE bubble between writes.
- Requester rules:
  - Deassert req, or present a new addr/data, in the cycle after gnt/err.
  - Changes to req_addr/req_data while in ISSUE have no effect (the values are latched).
- Simultaneous requests: only one gnt or err per cycle. A requester that keeps req high is served within NUM_REQ arbitration rounds (no starvation).
- Dropped requests: if a requester deasserts req before being granted, nothing is recorded for it.
- Reset asserted while in ISSUE:
  - The write is abandoned and no gnt is issued.
  - The file write may or may not have occurred; requesters must re-issue after reset.
- Pointer wrap: rr_ptr = NUM_REQ-1 advances to 0.
- rf_wr is never asserted with rf_select==ZERO_REG or rf_select >= NUM_REGS.

Decomposition:
- Shared package rf_pkg: WIDTH, ABITS, NUM_REGS, ZERO_REG constants; FSM state encoding (IDLE=0, ISSUE=1).
- One sub-module, rr_pick: combinational round-robin priority picker. Inputs: req vector, rr_ptr. Outputs: one-hot winner, winner index, any_valid. It is reusable for the future read-port arbiter.

Test Plan:
- Single requester: req[2]=1, addr=5, data=0xDEADBEEF, rf_ready=1 -> rf_wr=1 with select=5 and data=0xDEADBEEF one cycle later; gnt=4'b0100 in that same cycle; rr_ptr=3 afterwards.
- Fairness: all four req held high, rf_ready=1, rr_ptr=0 -> grant order 0,1,2,3,0, with exactly one gnt every 2 cycles.
- Protected and out-of-range writes: req[1]=1 with addr=31 -> err=4'b0010 in the same cycle and rf_wr stays 0. Repeat with NUM_REGS=24 and addr=26 -> err pulse.
- Stall: req[0]=1, addr=7, rf_ready=0 for 5 cycles then 1 -> rf_wr high for 6 cycles with select=7 stable throughout; gnt[0] pulses only in cycle 6; busy=1 for all 6 cycles.
- Reset mid-ISSUE: assert rst on the 2nd stall cycle -> rf_wr, busy and gnt drop to 0 immediately (asynchronous), no gnt is issued, rr_ptr=0; after release, the held req is re-arbitrated from index 0.
- Wrap: rr_ptr=3 with req=4'b1001 -> requester 3 is granted first, then requester 0.

Source files
------------

// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared constants and FSM encoding for the register-file write arbiter
package rf_pkg;

  localparam int WIDTH    = 32;
  localparam int ABITS    = 5;
  localparam int NUM_REGS = 32;
  localparam int ZERO_REG = 31;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin priority picker
// First set request at or above ptr wins, wrapping modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [PW-1:0] idx,
  output logic          any_valid
);

  int            j;
  logic [PW-1:0] jj;

  always_comb begin
    onehot    = '0;
    idx       = '0;
    any_valid = 1'b0;
    j         = 0;
    jj        = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      jj = PW'(j);
      if (!any_valid && req[jj]) begin
        any_valid  = 1'b1;
        idx        = jj;
        onehot[jj] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - round-robin arbiter for the register-file write port
// Bad addresses are rejected in IDLE so the file never sees them.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int WIDTH    = rf_pkg::WIDTH,
  parameter int ABITS    = rf_pkg::ABITS,
  parameter int NUM_REGS = rf_pkg::NUM_REGS,
  parameter int ZERO_REG = rf_pkg::ZERO_REG
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*ABITS-1:0] req_addr,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       err,
  output logic                     rf_wr,
  output logic [ABITS-1:0]         rf_select,
  output logic [WIDTH-1:0]         rf_data,
  input  logic                     rf_ready,
  output logic                     busy
);

  localparam int PW = $clog2(NUM_REQ);

  state_t               state;
  logic [PW-1:0]        rr_ptr;
  logic [PW-1:0]        win;
  logic [NUM_REQ-1:0]   pick_onehot;
  logic [PW-1:0]        pick_idx;
  logic                 pick_any;
  logic [ABITS-1:0]     sel_addr;
  logic [WIDTH-1:0]     sel_data;
  logic                 addr_bad;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(NUM_REQ - 1)) ? '0 : p + 1'b1;
  endfunction

  rr_pick #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_pick (
    .req       (req),
    .ptr       (rr_ptr),
    .onehot    (pick_onehot),
    .idx       (pick_idx),
    .any_valid (pick_any)
  );

  assign sel_addr = req_addr[int'(pick_idx)*ABITS +: ABITS];
  assign sel_data = req_data[int'(pick_idx)*WIDTH +: WIDTH];
  assign addr_bad = (sel_addr == ABITS'(ZERO_REG)) ||
                    ({1'b0, sel_addr} >= (ABITS+1)'(NUM_REGS));

  // Rejection is combinational; masked during reset so nothing pulses while held.
  assign err = (!rst && state == IDLE && pick_any && addr_bad) ? pick_onehot : '0;
  assign gnt = (state == ISSUE && rf_ready) ? (NUM_REQ'(1) << win) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      win       <= '0;
      rf_wr     <= 1'b0;
      busy      <= 1'b0;
      rf_select <= '0;
      rf_data   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            if (addr_bad) begin
              rr_ptr <= ptr_next(pick_idx);
            end else begin
              rf_select <= sel_addr;
              rf_data   <= sel_data;
              win       <= pick_idx;
              rf_wr     <= 1'b1;
              busy      <= 1'b1;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (rf_ready) begin
            rr_ptr <= ptr_next(win);
            rf_wr  <= 1'b0;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          rf_wr <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - scoreboard bench for rf_write_arbiter
module tb_rf_write_arbiter;

  localparam int NQ = 4;
  localparam int AB = 5;
  localparam int DW = 32;
  localparam int NR = 24;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NQ-1:0]   req = '0;
  logic [NQ*AB-1:0] req_addr = '0;
  logic [NQ*DW-1:0] req_data = '0;
  logic [NQ-1:0]   gnt;
  logic [NQ-1:0]   err;
  logic            rf_wr;
  logic [AB-1:0]   rf_select;
  logic [DW-1:0]   rf_data;
  logic            rf_ready = 1'b1;
  logic            busy;

  typedef struct {
    bit            is_err;
    logic [NQ-1:0] mask;
    logic [AB-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rf_write_arbiter #(
    .NUM_REQ  (NQ),
    .WIDTH    (DW),
    .ABITS    (AB),
    .NUM_REGS (NR),
    .ZERO_REG (31)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .gnt       (gnt),
    .err       (err),
    .rf_wr     (rf_wr),
    .rf_select (rf_select),
    .rf_data   (rf_data),
    .rf_ready  (rf_ready),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [AB-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AB +: AB] = a;
    req_data[i*DW +: DW] = d;
    req[i] = 1'b1;
  endtask

  task automatic expect_ev(input bit is_err, input int i, input logic [AB-1:0] a,
                           input logic [DW-1:0] d);
    exp_t e;
    e.is_err = is_err;
    e.mask   = NQ'(1) << i;
    e.addr   = a;
    e.data   = d;
    exp_q.push_back(e);
  endtask

  // Drives requesters until n gnt/err events occur; hold keeps requests up.
  task automatic run(input int n, input bit hold);
    int seen = 0;
    int cyc  = 0;
    int last = -1;
    logic [NQ-1:0] done;
    while (seen < n && cyc < 200) begin
      @(negedge clk);
      cyc++;
      done = gnt | err;
      if (done != 0) begin
        seen++;
        if (hold && gnt != 0 && last >= 0) chk("gnt_spacing", 32'(cyc - last), 32'd2);
        if (gnt != 0) last = cyc;
      end
      @(posedge clk);
      #1;
      if (hold) begin
        if (seen >= n) req = '0;
      end else begin
        req = req & ~done;
      end
    end
    chk("run_events", 32'(seen), 32'(n));
  endtask

  // Monitor: pops the scoreboard whenever a gnt or err pulse is presented.
  always @(negedge clk) begin
    if (!rst) begin
      if (rf_wr)
        chk("rf_wr_legal_addr", 32'((rf_select != 5'd31) && (rf_select < 5'(NR))), 32'd1);
      if (gnt != 0 || err != 0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event", {24'd0, gnt, err}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("gnt", 32'(gnt), e.is_err ? 32'd0 : 32'(e.mask));
          chk("err", 32'(err), e.is_err ? 32'(e.mask) : 32'd0);
          if (e.is_err) begin
            chk("rf_wr_on_err", 32'(rf_wr), 32'd0);
          end else begin
            chk("rf_wr_on_gnt", 32'(rf_wr), 32'd1);
            chk("rf_select", 32'(rf_select), 32'(e.addr));
            chk("rf_data", rf_data, e.data);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_rf_wr", 32'(rf_wr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rf_select", 32'(rf_select), 32'd0);
    chk("rst_rf_data", rf_data, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Fairness from rr_ptr=0: 0,1,2,3,0 one write every 2 cycles.
    for (int i = 0; i < NQ; i++) set_req(i, AB'(i + 1), 32'hA0 + 32'(i));
    for (int k = 0; k < 5; k++) expect_ev(1'b0, k % NQ, AB'((k % NQ) + 1), 32'hA0 + 32'(k % NQ));
    run(5, 1'b1);

    // Single requester (rr_ptr=1 now); leaves rr_ptr=3.
    set_req(2, 5'd5, 32'hDEADBEEF);
    expect_ev(1'b0, 2, 5'd5, 32'hDEADBEEF);
    run(1, 1'b0);

    // Wrap: rr_ptr=3 with req=1001 -> 3 then 0.
    set_req(0, 5'd1, 32'h11);
    set_req(3, 5'd2, 32'h33);
    expect_ev(1'b0, 3, 5'd2, 32'h33);
    expect_ev(1'b0, 0, 5'd1, 32'h11);
    run(2, 1'b0);

    // Protected, out-of-range, and highest legal address.
    set_req(1, 5'd31, 32'h1);
    expect_ev(1'b1, 1, 5'd31, 32'h1);
    run(1, 1'b0);
    set_req(1, 5'd26, 32'h2);
    expect_ev(1'b1, 1, 5'd26, 32'h2);
    run(1, 1'b0);
    set_req(1, 5'd23, 32'h3);
    expect_ev(1'b0, 1, 5'd23, 32'h3);
    run(1, 1'b0);

    // Stall five cycles; a late address change must not leak through.
    rf_ready = 1'b0;
    set_req(0, 5'd7, 32'h77);
    expect_ev(1'b0, 0, 5'd7, 32'h77);
    @(posedge clk);
    #1;
    for (int k = 1; k <= 6; k++) begin
      if (k == 6) rf_ready = 1'b1;
      if (k == 2) req_addr[4:0] = 5'd9;
      @(negedge clk);
      chk("stall_rf_wr", 32'(rf_wr), 32'd1);
      chk("stall_busy", 32'(busy), 32'd1);
      chk("stall_select", 32'(rf_select), 32'd7);
      if (k < 6) chk("stall_no_gnt", 32'(gnt), 32'd0);
      @(posedge clk);
      #1;
    end
    req = '0;
    @(negedge clk);
    chk("bubble_rf_wr", 32'(rf_wr), 32'd0);

    // Reset mid-ISSUE (rr_ptr=1 before): abandoned, then re-arbitrated from 0.
    @(posedge clk);
    #1;
    rf_ready = 1'b0;
    set_req(0, 5'd8, 32'h88);
    @(posedge clk);
    #1;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_rf_wr", 32'(rf_wr), 32'd0);
    chk("rst_async_busy", 32'(busy), 32'd0);
    chk("rst_async_gnt", 32'(gnt), 32'd0);
    set_req(1, 5'd9, 32'h99);
    rf_ready = 1'b1;
    expect_ev(1'b0, 0, 5'd8, 32'h88);
    expect_ev(1'b0, 1, 5'd9, 32'h99);
    @(posedge clk);
    #1 rst = 1'b0;
    run(2, 1'b0);

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
